fp_arith_unit: RTL and testbench

Parametrised, fully pipelined floating-point arithmetic unit that performs ADD, SUB or MUL on every cycle. The operation is selected per operand pair. It is the next generation of the single-function fpadd / FP_multiplier cores used by the VGG16 convolution datapath. It adds configurable exponent and mantissa widths, round-to-nearest-even, IEEE special-value handling and status flags. A single valid bit travels alongside the data; there is no backpressure.

---
 rtl/fp_arith_unit.sv | 267 ++++++++++++++++++++++++++
 tb/tb_fp_arith_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_arith_unit.sv
// fp_arith_unit: four-rank pipelined floating-point ADD / SUB / MUL.
// The first rank captures the input and the result appears three edges later.
// Rounding is to nearest with ties to even. Denormals are flushed to zero.
// The shared mantissa datapath assumes MAN_W >= 4.
module fp_arith_unit #(
  parameter  int EXP_W      = 8,
  parameter  int MAN_W      = 23,
  localparam int DATA_WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  valid_out,
  output logic                  overflow,
  output logic                  invalid
);

  localparam int EW2  = EXP_W + 2;
  localparam int MW   = 2 * MAN_W + 2;   // product width, binary point below bit MW-2
  localparam int SW   = MAN_W + 5;       // carry + hidden + fraction + G/R/S
  localparam int BW   = 2 * MAN_W + 4;   // alignment scratch width
  localparam int LZW  = $clog2(MW + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------- stage 1: unpack, classify, order operands ----------------
  logic               a_s, b_s, x_s, y_s;
  logic [EXP_W-1:0]   a_e, b_e, x_e, y_e;
  logic [MAN_W-1:0]   a_m, b_m, x_m, y_m;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               x_zero, y_zero, is_mul, swap;

  logic               s1_valid_d, s1_mul_d, s1_nan_d, s1_inf_d, s1_sign_d, s1_zsign_d, s1_sub_d;
  logic [EW2-1:0]     s1_exp_d;
  logic [EXP_W-1:0]   s1_diff_d;
  logic [MAN_W:0]     s1_ma_d, s1_mb_d;

  logic               s1_valid_q, s1_mul_q, s1_nan_q, s1_inf_q, s1_sign_q, s1_zsign_q, s1_sub_q;
  logic [EW2-1:0]     s1_exp_q;
  logic [EXP_W-1:0]   s1_diff_q;
  logic [MAN_W:0]     s1_ma_q, s1_mb_q;

  // Split fields, classify, flip SUB sign, order ADD/SUB operands by magnitude.
  always_comb begin
    a_s    = in1[DATA_WIDTH-1];
    a_e    = in1[DATA_WIDTH-2 -: EXP_W];
    a_m    = in1[MAN_W-1:0];
    b_s    = in2[DATA_WIDTH-1] ^ (op == OP_SUB);
    b_e    = in2[DATA_WIDTH-2 -: EXP_W];
    b_m    = in2[MAN_W-1:0];
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    a_inf  = (a_e == '1) && (a_m == '0);
    b_inf  = (b_e == '1) && (b_m == '0);
    a_nan  = (a_e == '1) && (a_m != '0);
    b_nan  = (b_e == '1) && (b_m != '0);
    is_mul = (op == OP_MUL);
    swap   = !is_mul && ({b_e, b_m} > {a_e, a_m});

    x_s    = swap ? b_s : a_s;
    x_e    = swap ? b_e : a_e;
    x_m    = swap ? b_m : a_m;
    y_s    = swap ? a_s : b_s;
    y_e    = swap ? a_e : b_e;
    y_m    = swap ? a_m : b_m;
    x_zero = (x_e == '0);
    y_zero = (y_e == '0);

    s1_valid_d = valid_in;
    s1_mul_d   = is_mul;
    s1_nan_d   = a_nan | b_nan | (op == OP_RSV) |
                 (is_mul ? ((a_zero & b_inf) | (a_inf & b_zero))
                         : (a_inf & b_inf & (a_s != b_s)));
    s1_inf_d   = a_inf | b_inf;
    s1_sign_d  = is_mul ? (a_s ^ b_s) : x_s;
    // Exact cancellation gives +0; only -0 + -0 keeps the negative sign.
    s1_zsign_d = is_mul ? (a_s ^ b_s) : (a_zero & b_zero & a_s & b_s);
    s1_sub_d   = x_s ^ y_s;
    s1_exp_d   = is_mul ? (EW2'(a_e) + EW2'(b_e) - EW2'(BIAS)) : EW2'(x_e);
    s1_diff_d  = x_e - y_e;
    s1_ma_d    = x_zero ? '0 : {1'b1, x_m};
    s1_mb_d    = y_zero ? '0 : {1'b1, y_m};
  end

  // Rank 1 register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_mul_q   <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zsign_q <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_diff_q  <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mul_q   <= s1_mul_d;
      s1_nan_q   <= s1_nan_d;
      s1_inf_q   <= s1_inf_d;
      s1_sign_q  <= s1_sign_d;
      s1_zsign_q <= s1_zsign_d;
      s1_sub_q   <= s1_sub_d;
      s1_exp_q   <= s1_exp_d;
      s1_diff_q  <= s1_diff_d;
      s1_ma_q    <= s1_ma_d;
      s1_mb_q    <= s1_mb_d;
    end
  end

  // ---------------- stage 2: align + add/sub, or multiply ----------------
  logic [EXP_W-1:0] sh;
  logic [BW-1:0]    big, big_sh;
  logic [SW-1:0]    a_al, b_al, sum;
  logic [MW-1:0]    prod;
  logic [MW-1:0]    s2_m_d, s2_m_q;
  logic [EW2-1:0]   s2_exp_q;
  logic             s2_valid_q, s2_nan_q, s2_inf_q, s2_sign_q, s2_zsign_q;

  // Shift the smaller mantissa right keeping G/R/S and map both paths onto one format.
  always_comb begin
    if (int'(s1_diff_q) > MAN_W + 3) sh = EXP_W'(MAN_W + 3);
    else                             sh = s1_diff_q;
    big    = {s1_mb_q, {(MAN_W+3){1'b0}}};
    big_sh = big >> sh;
    a_al   = {1'b0, s1_ma_q, 3'b000};
    b_al   = {1'b0, big_sh[BW-1 -: MAN_W+3], |big_sh[MAN_W:0]};
    sum    = s1_sub_q ? (a_al - b_al) : (a_al + b_al);
    prod   = MW'(s1_ma_q) * MW'(s1_mb_q);
    s2_m_d = s1_mul_q ? prod : {sum, {(MAN_W-3){1'b0}}};
  end

  // Rank 2 register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid_q <= 1'b0;
      s2_nan_q   <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zsign_q <= 1'b0;
      s2_exp_q   <= '0;
      s2_m_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_nan_q   <= s1_nan_q;
      s2_inf_q   <= s1_inf_q;
      s2_sign_q  <= s1_sign_q;
      s2_zsign_q <= s1_zsign_q;
      s2_exp_q   <= s1_exp_q;
      s2_m_q     <= s2_m_d;
    end
  end

  // ---------------- stage 3: normalise ----------------
  // A leading-zero count of 0 is the 1-bit right shift (carry or product >= 2).
  // Larger counts are the left shift after cancellation.
  logic [LZW-1:0]   lzc;
  logic [MW-1:0]    s3_n_d, s3_n_q;
  logic [EW2-1:0]   s3_exp_d, s3_exp_q;
  logic             s3_zero_d;
  logic             s3_valid_q, s3_nan_q, s3_inf_q, s3_sign_q, s3_zsign_q, s3_zero_q;

  // Count leading zeros and move the leading one to the top bit.
  always_comb begin
    lzc = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (s2_m_q[i]) lzc = LZW'(MW - 1 - i);
    end
    s3_zero_d = (s2_m_q == '0);
    s3_n_d    = s2_m_q << lzc;
    s3_exp_d  = s2_exp_q + EW2'(1) - EW2'(lzc);
  end

  // Rank 3 register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s3_valid_q <= 1'b0;
      s3_nan_q   <= 1'b0;
      s3_inf_q   <= 1'b0;
      s3_sign_q  <= 1'b0;
      s3_zsign_q <= 1'b0;
      s3_zero_q  <= 1'b0;
      s3_exp_q   <= '0;
      s3_n_q     <= '0;
    end else begin
      s3_valid_q <= s2_valid_q;
      s3_nan_q   <= s2_nan_q;
      s3_inf_q   <= s2_inf_q;
      s3_sign_q  <= s2_sign_q;
      s3_zsign_q <= s2_zsign_q;
      s3_zero_q  <= s3_zero_d;
      s3_exp_q   <= s3_exp_d;
      s3_n_q     <= s3_n_d;
    end
  end

  // ---------------- stage 4: round, special cases, pack ----------------
  logic [MAN_W-1:0]      frac;
  logic                  g_bit, s_bit, rnd;
  logic [MAN_W:0]        mant_r;
  logic [EW2-1:0]        exp_r;
  logic [DATA_WIDTH-1:0] result_d, result_q;
  logic                  ovf_raw, inv_raw;
  logic                  valid_out_q, overflow_d, overflow_q, invalid_d, invalid_q;

  // Round to nearest even, absorb the rounding carry, then apply special-case priority.
  always_comb begin
    frac     = s3_n_q[MW-2 -: MAN_W];
    g_bit    = s3_n_q[MW-2-MAN_W];
    s_bit    = |s3_n_q[MW-3-MAN_W:0];
    rnd      = g_bit & (s_bit | frac[0]);
    mant_r   = {1'b0, frac} + {{MAN_W{1'b0}}, rnd};
    exp_r    = s3_exp_q + {{(EW2-1){1'b0}}, mant_r[MAN_W]};
    result_d = {s3_sign_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
    ovf_raw  = 1'b0;
    inv_raw  = 1'b0;
    if (s3_nan_q) begin
      result_d = QNAN;
      inv_raw  = 1'b1;
    end else if (s3_inf_q) begin
      result_d = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s3_zero_q) begin
      result_d = {s3_zsign_q, {(EXP_W+MAN_W){1'b0}}};
    end else if (!exp_r[EW2-1] && (exp_r >= EW2'(EMAX))) begin
      result_d = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_raw  = 1'b1;
    end else if (exp_r[EW2-1] || (exp_r == '0)) begin
      result_d = {s3_sign_q, {(EXP_W+MAN_W){1'b0}}};
    end
    overflow_d = s3_valid_q & ovf_raw;
    invalid_d  = s3_valid_q & inv_raw;
  end

  // Output register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q    <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      result_q    <= result_d;
      valid_out_q <= s3_valid_q;
      overflow_q  <= overflow_d;
      invalid_q   <= invalid_d;
    end
  end

  assign result    = result_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_fp_arith_unit.sv
// tb_fp_arith_unit: scoreboard bench for single- and half-precision instances.
module tb_fp_arith_unit;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] RSV = 2'b11;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sp_vi, sp_vo, sp_ovf, sp_inv;
  logic [1:0]  sp_op;
  logic [31:0] sp_in1, sp_in2, sp_res;
  logic        hp_vi, hp_vo, hp_ovf, hp_inv;
  logic [1:0]  hp_op;
  logic [15:0] hp_in1, hp_in2, hp_res;

  fp_arith_unit u_sp (
    .clk(clk), .resetn(resetn), .valid_in(sp_vi), .op(sp_op),
    .in1(sp_in1), .in2(sp_in2), .result(sp_res), .valid_out(sp_vo),
    .overflow(sp_ovf), .invalid(sp_inv)
  );

  fp_arith_unit #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .resetn(resetn), .valid_in(hp_vi), .op(hp_op),
    .in1(hp_in1), .in2(hp_in2), .result(hp_res), .valid_out(hp_vo),
    .overflow(hp_ovf), .invalid(hp_inv)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        inv;
    int          due;
  } exp_t;

  exp_t sp_q[$];
  exp_t hp_q[$];
  exp_t sp_e, hp_e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Drive one single-precision operation; its result is due four negedges later.
  task automatic sp_issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic ov, input logic iv);
    exp_t e;
    sp_op  = o;
    sp_in1 = a;
    sp_in2 = b;
    sp_vi  = 1'b1;
    e.res = r; e.ovf = ov; e.inv = iv; e.due = cyc + 4;
    sp_q.push_back(e);
  endtask

  task automatic hp_issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r, input logic ov, input logic iv);
    exp_t e;
    hp_op  = o;
    hp_in1 = a;
    hp_in2 = b;
    hp_vi  = 1'b1;
    e.res = {16'd0, r}; e.ovf = ov; e.inv = iv; e.due = cyc + 4;
    hp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (sp_q.size() > 0 || hp_q.size() > 0); i++) @(negedge clk);
    #1;
    chk("drain_sp", 32'(sp_q.size()), 32'd0);
    chk("drain_hp", 32'(hp_q.size()), 32'd0);
  endtask

  // Single-precision output monitor.
  always @(negedge clk) begin
    if (resetn) begin
      if (sp_vo) begin
        if (sp_q.size() == 0) begin
          chk("sp_unexpected", 32'(sp_vo), 32'd0);
        end else begin
          sp_e = sp_q.pop_front();
          chk("sp_result", sp_res, sp_e.res);
          chk("sp_flags", {30'd0, sp_ovf, sp_inv}, {30'd0, sp_e.ovf, sp_e.inv});
          chk("sp_latency", 32'(cyc), 32'(sp_e.due));
        end
      end else begin
        chk("sp_idle_flags", {30'd0, sp_ovf, sp_inv}, 32'd0);
        if (sp_q.size() > 0 && sp_q[0].due <= cyc) begin
          chk("sp_missing", 32'(sp_vo), 32'd1);
          sp_q.delete(0);
        end
      end
    end
  end

  // Half-precision output monitor.
  always @(negedge clk) begin
    if (resetn) begin
      if (hp_vo) begin
        if (hp_q.size() == 0) begin
          chk("hp_unexpected", 32'(hp_vo), 32'd0);
        end else begin
          hp_e = hp_q.pop_front();
          chk("hp_result", {16'd0, hp_res}, hp_e.res);
          chk("hp_flags", {30'd0, hp_ovf, hp_inv}, {30'd0, hp_e.ovf, hp_e.inv});
          chk("hp_latency", 32'(cyc), 32'(hp_e.due));
        end
      end else begin
        chk("hp_idle_flags", {30'd0, hp_ovf, hp_inv}, 32'd0);
        if (hp_q.size() > 0 && hp_q[0].due <= cyc) begin
          chk("hp_missing", 32'(hp_vo), 32'd1);
          hp_q.delete(0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int pat[7] = '{1, 1, 0, 0, 1, 0, 1};

  initial begin
    sp_vi = 1'b0; sp_op = ADD; sp_in1 = '0; sp_in2 = '0;
    hp_vi = 1'b0; hp_op = ADD; hp_in1 = '0; hp_in2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sp_result", sp_res, 32'd0);
    chk("rst_sp_outs", {29'd0, sp_vo, sp_ovf, sp_inv}, 32'd0);
    chk("rst_hp_result", {16'd0, hp_res}, 32'd0);
    chk("rst_hp_outs", {29'd0, hp_vo, hp_ovf, hp_inv}, 32'd0);
    resetn = 1'b1;

    // Single ADD pulse.
    @(negedge clk) sp_issue(ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    @(negedge clk) sp_vi = 1'b0;
    drain();

    // Back-to-back mixed ops, rounding ties and special values.
    @(negedge clk) sp_issue(MUL, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(SUB, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(ADD, 32'h3F800000, 32'hBF000000, 32'h3F000000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(ADD, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0);
    @(negedge clk) sp_issue(ADD, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(MUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b1, 1'b0);
    @(negedge clk) sp_issue(ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
    @(negedge clk) sp_issue(SUB, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1);
    @(negedge clk) sp_issue(MUL, 32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1);
    @(negedge clk) sp_issue(RSV, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1);
    @(negedge clk) sp_issue(ADD, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1);
    @(negedge clk) sp_issue(ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(MUL, 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(MUL, 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(ADD, 32'hC0000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0);
    @(negedge clk) sp_vi = 1'b0;
    drain();

    // Bubble pattern 1,1,0,0,1,0,1.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (pat[i] == 0) sp_vi = 1'b0;
      else case (i)
        0:       sp_issue(MUL, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);
        1:       sp_issue(SUB, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
        4:       sp_issue(ADD, 32'hC0000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0);
        default: sp_issue(ADD, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 1'b0, 1'b0);
      endcase
    end
    @(negedge clk) sp_vi = 1'b0;
    drain();

    // Half precision instance.
    @(negedge clk) hp_issue(ADD, 16'h3C00, 16'h4000, 16'h4200, 1'b0, 1'b0);
    @(negedge clk) hp_issue(MUL, 16'h4000, 16'h4200, 16'h4600, 1'b0, 1'b0);
    @(negedge clk) hp_vi = 1'b0;
    drain();

    // Reset mid-stream: in-flight operations must never appear.
    @(negedge clk) sp_issue(ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(MUL, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    sp_op = ADD; sp_in1 = 32'h3F800000; sp_in2 = 32'h3F800000; sp_vi = 1'b1;
    sp_q.delete();
    hp_q.delete();
    #1;
    chk("midrst_sp_result", sp_res, 32'd0);
    chk("midrst_sp_outs", {29'd0, sp_vo, sp_ovf, sp_inv}, 32'd0);
    chk("midrst_hp_outs", {29'd0, hp_vo, hp_ovf, hp_inv}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    sp_issue(SUB, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    @(negedge clk) sp_issue(ADD, 32'h3F800000, 32'hBF000000, 32'h3F000000, 1'b0, 1'b0);
    @(negedge clk) sp_vi = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
